// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with packet lock and lock timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   uart_tx_load,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_ready,
  output logic                   busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int TOM = LOCK_TIMEOUT > 0 ? LOCK_TIMEOUT - 1 : 0;
  typedef enum logic [1:0] {IDLE, LOAD, GUARD, WAIT} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, owner, sel, idx, owner_inc;
  logic [CW-1:0] cnt;
  logic found, go, lock, last_q, stale;
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    if (lock) begin
      sel = owner;
      found = req_valid[owner];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          sel = idx;
        end
      end
    end
  end
  assign owner_inc = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign go = state == IDLE && uart_tx_ready && found;
  assign stale = LOCK_TIMEOUT != 0 && state == IDLE && lock && !req_valid[owner];
  always_comb begin
    state_n = state == IDLE  ? (go ? LOAD : IDLE) :
              state == LOAD  ? GUARD :
              state == GUARD ? WAIT :
              (uart_tx_ready ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ack <= '0;
      grant <= '0;
      uart_tx_load <= 1'b0;
      uart_tx_data <= 8'h00;
      busy <= 1'b0;
      rr_ptr <= '0;
      owner <= '0;
      lock <= 1'b0;
      last_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      uart_tx_load <= go;
      req_ack <= go ? NUM_REQ'(1) << sel : '0;
      if (go) begin
        owner <= sel;
        uart_tx_data <= req_data[{sel, 3'b000} +: 8];
        last_q <= req_last[sel];
        grant <= NUM_REQ'(1) << sel;
      end
      if (state == LOAD) begin
        lock <= !last_q;
        cnt <= '0;
        if (last_q) rr_ptr <= owner_inc;
      end
      if (state == WAIT && uart_tx_ready && !lock) grant <= '0;
      if (stale) begin
        if (cnt == CW'(TOM)) begin
          lock <= 1'b0;
          grant <= '0;
          rr_ptr <= owner_inc;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests checked against a transaction-level arbitration model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 8;
  localparam int BUSY_T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] req_ack, grant;
  logic uart_tx_load, busy;
  logic [7:0] uart_tx_data;
  logic uart_tx_ready = 1'b1;
  int n_cmp = 0, n_err = 0;
  int log_idx[$];
  logic [7:0] log_dat[$];
  int tx_left = 0;
  bit pend = 0, auto_tx = 1, started = 0;
  bit m_idle = 1, m_lock = 0;
  int m_since = 0, m_owner = 0, m_rr = 0, m_cnt = 0, pick;
  logic e_load = 0, e_busy = 0;
  logic [N-1:0] e_ack = '0, e_grant = '0;
  logic [7:0] e_data = '0;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .uart_tx_load(uart_tx_load), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_idle = 1; m_lock = 0; m_since = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
      e_load = 0; e_ack = '0; e_data = '0; e_grant = '0; e_busy = 0;
    end else begin
      e_load = 0;
      e_ack = '0;
      if (m_idle) begin
        pick = -1;
        if (m_lock) begin
          if (req_valid[m_owner]) pick = m_owner;
        end else begin
          for (int k = 0; k < N; k++)
            if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
        end
        if (pick >= 0 && uart_tx_ready) begin
          m_idle = 0; m_since = 0; m_cnt = 0; m_owner = pick;
          e_load = 1;
          e_ack = N'(1 << pick);
          e_data = req_data[8*pick +: 8];
          if (req_last[pick]) begin
            m_lock = 0;
            m_rr = (pick + 1) % N;
          end else m_lock = 1;
        end else if (m_lock && !req_valid[m_owner]) begin
          m_cnt++;
          if (m_cnt == TO) begin
            m_lock = 0;
            m_rr = (m_owner + 1) % N;
            m_cnt = 0;
          end
        end
      end else begin
        if (m_since >= 2 && uart_tx_ready) m_idle = 1;
        m_since++;
      end
      e_busy = !m_idle;
      e_grant = (!m_idle || m_lock) ? N'(1 << m_owner) : '0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("load", uart_tx_load, e_load);
      chk("ack", req_ack, e_ack);
      chk("data", uart_tx_data, e_data);
      chk("grant", grant, e_grant);
      chk("busy", busy, e_busy);
      if (uart_tx_load) begin
        for (int k = 0; k < N; k++) if (req_ack[k]) log_idx.push_back(k);
        log_dat.push_back(uart_tx_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_tx) begin
      if (pend) begin
        uart_tx_ready = 0;
        tx_left = BUSY_T;
        pend = 0;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) uart_tx_ready = 1;
      end
      if (uart_tx_load) pend = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    req_last = '0;
    step();
    step();
    rst = 0;
    auto_tx = 1; pend = 0; tx_left = 0; uart_tx_ready = 1;
    log_idx.delete();
    log_dat.delete();
  endtask

  task automatic run(input int n, input bit clr);
    int c = 0;
    while (log_idx.size() < n && c < 400) begin
      step();
      if (clr) for (int k = 0; k < N; k++) if (req_ack[k]) req_valid[k] = 0;
      c++;
    end
    if (log_idx.size() < n) chk("timeout_loads", log_idx.size(), n);
  endtask

  task automatic wait_idle();
    int c = 0;
    step();
    while (busy && c < 100) begin
      step();
      c++;
    end
    if (busy) chk("timeout_idle", busy, 0);
  endtask

  task automatic exp_log(input string nm, input int pos, input int idx, input logic [7:0] d);
    if (pos >= log_idx.size()) chk({nm, "_missing"}, log_idx.size(), pos + 1);
    else begin
      chk({nm, "_idx"}, log_idx[pos], idx);
      chk({nm, "_data"}, log_dat[pos], d);
    end
  endtask

  initial begin
    int held, n2;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", uart_tx_data, 8'h00);
    chk("rst_load", uart_tx_load, 0);
    rst = 0;
    log_idx.delete();
    log_dat.delete();
    req_data[7:0] = 8'h41;
    req_last = 4'b0001;
    req_valid = 4'b0001;
    step();
    chk("t1_load", uart_tx_load, 1);
    chk("t1_data", uart_tx_data, 8'h41);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_grant", grant, 4'b0001);
    req_valid = 0;
    wait_idle();
    chk("t1_grant_clr", grant, 0);
    log_idx.delete();
    log_dat.delete();
    req_data[7:0] = 8'h42;
    req_data[15:8] = 8'h43;
    req_last = 4'b1111;
    req_valid = 4'b0011;
    run(2, 1);
    exp_log("t1_rr0", 0, 1, 8'h43);
    exp_log("t1_rr1", 1, 0, 8'h42);
    wait_idle();

    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_last = 4'b1111;
    req_valid = 4'b1111;
    run(5, 0);
    req_valid = 0;
    wait_idle();
    exp_log("t2_0", 0, 0, 8'h10);
    exp_log("t2_1", 1, 1, 8'h11);
    exp_log("t2_2", 2, 2, 8'h12);
    exp_log("t2_3", 3, 3, 8'h13);
    exp_log("t2_4", 4, 0, 8'h10);

    do_reset();
    req_data[23:16] = 8'h20;
    req_last = 4'b0000;
    req_valid = 4'b0100;
    n2 = 0;
    for (int c = 0; c < 400 && log_idx.size() < 4; c++) begin
      step();
      if (n2 == 1 || n2 == 2) chk("t3_pkt_grant", grant, 4'b0100);
      if (req_ack[2]) begin
        n2++;
        if (n2 == 1) begin
          req_data[23:16] = 8'h21;
          req_data[15:8] = 8'h1A;
          req_last[1] = 1;
          req_valid[1] = 1;
        end else if (n2 == 2) begin
          req_data[23:16] = 8'h22;
          req_last[2] = 1;
        end else req_valid[2] = 0;
      end
      if (req_ack[1]) req_valid[1] = 0;
    end
    wait_idle();
    exp_log("t3_0", 0, 2, 8'h20);
    exp_log("t3_1", 1, 2, 8'h21);
    exp_log("t3_2", 2, 2, 8'h22);
    exp_log("t3_3", 3, 1, 8'h1A);

    do_reset();
    req_data[15:8] = 8'h31;
    req_last = 4'b1000;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1000;
    req_data[31:24] = 8'h33;
    held = 0;
    for (int c = 0; c < 400 && log_idx.size() < 2; c++) begin
      step();
      if (!busy && grant == 4'b0010) held++;
      if (req_ack[3]) req_valid[3] = 0;
    end
    wait_idle();
    chk("t4_held_cycles", held, TO);
    exp_log("t4_0", 0, 1, 8'h31);
    exp_log("t4_1", 1, 3, 8'h33);

    do_reset();
    req_data[23:16] = 8'h55;
    req_last = 4'b1111;
    req_valid = 4'b0100;
    for (int c = 0; c < 50 && !(busy && !uart_tx_ready); c++) step();
    auto_tx = 0;
    uart_tx_ready = 0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h05;
    step();
    step();
    rst = 1;
    step();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_data", uart_tx_data, 8'h00);
    rst = 0;
    for (int c = 0; c < 5; c++) step();
    chk("t5_no_load", log_idx.size(), 1);
    uart_tx_ready = 1;
    tx_left = 0;
    pend = 0;
    auto_tx = 1;
    run(2, 1);
    wait_idle();
    exp_log("t5_0", 0, 2, 8'h55);
    exp_log("t5_1", 1, 0, 8'h05);

    do_reset();
    req_data[7:0] = 8'h66;
    req_last = 4'b0001;
    req_valid = 4'b0001;
    step();
    req_valid = 0;
    req_data[7:0] = 8'h99;
    chk("t6_ack", req_ack, 4'b0001);
    step();
    wait_idle();
    exp_log("t6_0", 0, 0, 8'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
